// File: rtl/cv32e40p_pkg2.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_pkg2
// Purpose : Shared constants and types for the IF-stage fault-tolerance
//           breakage scheduler (module indices, counter defaults, FSM enum).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cv32e40p_pkg2;

  // Replicas per triplicated sub-block and number of monitored sub-blocks
  localparam int N_REP = 3;
  localparam int N_MOD = 6;

  // Sub-block indices into the err/broken vectors (bit = index*N_REP + replica)
  localparam int CVIFST_PCFT     = 0;
  localparam int CVIFST_PRBUFT   = 1;
  localparam int CVIFST_IFFSMFT  = 2;
  localparam int CVIFST_IFPIPEFT = 3;
  localparam int CVIFST_ALIGNFT  = 4;
  localparam int CVIFST_CDECFT   = 5;

  // Breakage counter defaults
  localparam int PRBU_COUNT_BIT   = 8;
  localparam int PRBU_INC_DEC_BIT = 2;
  localparam int PRBU_INCREMENT   = 1;
  localparam int PRBU_DECREMENT   = 1;
  localparam int PRBU_BRK_THRESH  = 3;

  typedef enum logic {
    FT_SCHED_IDLE,
    FT_SCHED_REPORT
  } ft_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_breakage_counter.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_breakage_counter
// Purpose : One saturating leaky mismatch counter with a sticky broken flag.
// Ports   : clk, rst_n      - clock, synchronous active-low reset
//           enable          - counter may move this cycle
//           clear           - zero counter and broken flag (highest priority)
//           err             - voter mismatch for this replica
//           broken          - sticky broken flag (registered)
//           break_set       - this edge will set the broken flag
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40p_breakage_counter #(
  parameter int                   COUNT_BIT   = 8,
  parameter int                   INC_DEC_BIT = 2,
  parameter logic [INC_DEC_BIT-1:0] INCREMENT = 1,
  parameter logic [INC_DEC_BIT-1:0] DECREMENT = 1,
  parameter int                   BRK_THRESH  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic err,
  output logic broken,
  output logic break_set
);

  localparam logic [COUNT_BIT:0] CNT_MAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0] THRESH  = (COUNT_BIT+1)'(BRK_THRESH);
  localparam logic [COUNT_BIT:0] INC_EXT = {{(COUNT_BIT+1-INC_DEC_BIT){1'b0}}, INCREMENT};
  localparam logic [COUNT_BIT:0] DEC_EXT = {{(COUNT_BIT+1-INC_DEC_BIT){1'b0}}, DECREMENT};

  logic [COUNT_BIT-1:0] count;
  logic [COUNT_BIT:0]   wide;
  logic [COUNT_BIT:0]   updated;
  logic                 update_en;

  assign wide      = {1'b0, count};
  // A broken replica freezes its counter; clear overrides everything.
  assign update_en = enable & ~broken & ~clear;

  // One extra bit of headroom so the clamp can see overflow/underflow.
  always_comb begin
    updated = wide;
    if (err) begin
      updated = ((wide + INC_EXT) > CNT_MAX) ? CNT_MAX : (wide + INC_EXT);
    end else begin
      updated = (wide < DEC_EXT) ? '0 : (wide - DEC_EXT);
    end
  end

  assign break_set = update_en & (updated >= THRESH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      broken <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      broken <= 1'b0;
    end else if (update_en) begin
      count <= updated[COUNT_BIT-1:0];
      if (updated >= THRESH) begin
        broken <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cv32e40p_if_ft_breakage_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_if_ft_breakage_scheduler
// Purpose : Breakage monitor for the six triplicated IF-stage sub-blocks.
//           Counts voter mismatches per replica, latches sticky broken
//           flags, raises fatal when two replicas of a block are broken and
//           reports each new breakage over a round-robin valid/ready channel.
// Ports   : clk, rst_n        - clock, synchronous active-low reset
//           enable_i          - monitoring enable (counters hold when low)
//           clear_i           - clear counters, broken and pending bits
//           err_i             - mismatch per replica, bit m*N_REP+r
//           set_broken_o      - sticky broken flags to the voters
//           fatal_o           - >=2 replicas of module m broken
//           rep_valid_o/rep_ready_i - report handshake
//           rep_mod_o, rep_replica_o - report payload
//           pending_o         - an unreported breakage exists
// Revision: 1.0 - initial release
// ============================================================================
module cv32e40p_if_ft_breakage_scheduler
  import cv32e40p_pkg2::*;
#(
  parameter int N_MOD       = cv32e40p_pkg2::N_MOD,
  parameter int N_REP       = cv32e40p_pkg2::N_REP,
  parameter int COUNT_BIT   = PRBU_COUNT_BIT,
  parameter int INC_DEC_BIT = PRBU_INC_DEC_BIT,
  parameter int INCREMENT   = PRBU_INCREMENT,
  parameter int DECREMENT   = PRBU_DECREMENT,
  parameter int BRK_THRESH  = PRBU_BRK_THRESH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [N_MOD*N_REP-1:0] err_i,
  output logic [N_MOD*N_REP-1:0] set_broken_o,
  output logic [N_MOD-1:0]       fatal_o,
  output logic                   rep_valid_o,
  input  logic                   rep_ready_i,
  output logic [2:0]             rep_mod_o,
  output logic [1:0]             rep_replica_o,
  output logic                   pending_o
);

  localparam int NK    = N_MOD * N_REP;
  localparam int IDX_W = $clog2(NK);

  logic [NK-1:0]    broken;
  logic [NK-1:0]    break_set;
  logic [NK-1:0]    broken_nxt;
  logic [N_MOD-1:0] fatal_nxt;

  logic [NK-1:0]    pending;
  logic [NK-1:0]    pending_nxt;
  logic [NK-1:0]    ack_mask;

  ft_sched_state_e  state;
  ft_sched_state_e  state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_nxt;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] grant_nxt;
  logic [2:0]       rep_mod_nxt;
  logic [1:0]       rep_replica_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] cand_idx;

  // --------------------------------------------------------------------------
  // Per-replica counters
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NK; k++) begin : g_rep
      cv32e40p_breakage_counter #(
        .COUNT_BIT   (COUNT_BIT),
        .INC_DEC_BIT (INC_DEC_BIT),
        .INCREMENT   (INC_DEC_BIT'(INCREMENT)),
        .DECREMENT   (INC_DEC_BIT'(DECREMENT)),
        .BRK_THRESH  (BRK_THRESH)
      ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable_i),
        .clear     (clear_i),
        .err       (err_i[k]),
        .broken    (broken[k]),
        .break_set (break_set[k])
      );
    end
  endgenerate

  assign set_broken_o = broken;

  // fatal is registered alongside broken, so derive it from broken's next value.
  assign broken_nxt = clear_i ? '0 : (broken | break_set);

  always_comb begin
    fatal_nxt = '0;
    for (int m = 0; m < N_MOD; m++) begin
      fatal_nxt[m] = ($countones(broken_nxt[m*N_REP +: N_REP]) >= 2);
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pick: first pending bit at or after rr_ptr, wrapping
  // --------------------------------------------------------------------------
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NK; i++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + i) % NK);
      if (!pick_found && pending[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Report FSM: next-state and payload
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant;
    rep_mod_nxt     = rep_mod_o;
    rep_replica_nxt = rep_replica_o;
    ack_mask        = '0;
    case (state)
      FT_SCHED_IDLE: begin
        if (pick_found) begin
          state_nxt       = FT_SCHED_REPORT;
          grant_nxt       = pick_idx;
          rep_mod_nxt     = 3'(int'(pick_idx) / N_REP);
          rep_replica_nxt = 2'(int'(pick_idx) % N_REP);
        end
      end
      FT_SCHED_REPORT: begin
        if (rep_ready_i) begin
          state_nxt  = FT_SCHED_IDLE;
          ack_mask   = NK'(1) << grant;
          rr_ptr_nxt = (grant == IDX_W'(NK-1)) ? '0 : grant + 1'b1;
        end
      end
      default: begin
        state_nxt = FT_SCHED_IDLE;
      end
    endcase
  end

  // New breakages only ever add pending bits; an accepted report removes its own.
  assign pending_nxt = clear_i ? '0 : ((pending & ~ack_mask) | break_set);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= FT_SCHED_IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      rep_mod_o     <= '0;
      rep_replica_o <= '0;
      pending       <= '0;
      fatal_o       <= '0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant         <= grant_nxt;
      rep_mod_o     <= rep_mod_nxt;
      rep_replica_o <= rep_replica_nxt;
      pending       <= pending_nxt;
      fatal_o       <= fatal_nxt;
    end
  end

  assign rep_valid_o = (state == FT_SCHED_REPORT);
  assign pending_o   = |pending;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_if_ft_breakage_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_cv32e40p_if_ft_breakage_scheduler
// Purpose : Self-checking bench for the IF-stage breakage scheduler, with a
//           behavioural model of counters, pending set and report channel.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_cv32e40p_if_ft_breakage_scheduler;

  localparam int NK   = 18;
  localparam int NM   = 6;
  localparam int TH   = 3;
  localparam int MAXC = 255;

  logic          clk;
  logic          rst_n;
  logic          enable_i;
  logic          clear_i;
  logic [NK-1:0] err_i;
  logic [NK-1:0] set_broken_o;
  logic [NM-1:0] fatal_o;
  logic          rep_valid_o;
  logic          rep_ready_i;
  logic [2:0]    rep_mod_o;
  logic [1:0]    rep_replica_o;
  logic          pending_o;

  // second instance with an unreachable-until-saturation threshold
  logic [NK-1:0] err_s;
  logic [NK-1:0] s_set_broken;
  logic [NM-1:0] s_fatal;
  logic          s_valid;
  logic [2:0]    s_mod;
  logic [1:0]    s_rep;
  logic          s_pending;

  int n_assert;
  int n_fail;

  // model state
  int m_cnt   [NK];
  bit m_brk   [NK];
  bit m_pend  [NK];
  bit m_valid;
  int m_mod, m_rep, m_grant, m_ptr;

  cv32e40p_if_ft_breakage_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .err_i         (err_i),
    .set_broken_o  (set_broken_o),
    .fatal_o       (fatal_o),
    .rep_valid_o   (rep_valid_o),
    .rep_ready_i   (rep_ready_i),
    .rep_mod_o     (rep_mod_o),
    .rep_replica_o (rep_replica_o),
    .pending_o     (pending_o)
  );

  cv32e40p_if_ft_breakage_scheduler #(.BRK_THRESH(255)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .clear_i       (clear_i),
    .err_i         (err_s),
    .set_broken_o  (s_set_broken),
    .fatal_o       (s_fatal),
    .rep_valid_o   (s_valid),
    .rep_ready_i   (rep_ready_i),
    .rep_mod_o     (s_mod),
    .rep_replica_o (s_rep),
    .pending_o     (s_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit ack  [NK];
    bit setp [NK];
    int g;
    int k;
    if (!rst_n) begin
      for (int i = 0; i < NK; i++) begin
        m_cnt[i] = 0; m_brk[i] = 0; m_pend[i] = 0;
      end
      m_valid = 0; m_mod = 0; m_rep = 0; m_grant = 0; m_ptr = 0;
      return;
    end
    for (int i = 0; i < NK; i++) begin
      ack[i] = 0; setp[i] = 0;
    end
    // report channel, from pre-edge pending
    if (!m_valid) begin
      g = -1;
      for (int i = 0; i < NK; i++) begin
        k = (m_ptr + i) % NK;
        if (g < 0 && m_pend[k]) g = k;
      end
      if (g >= 0) begin
        m_valid = 1; m_grant = g; m_mod = g / 3; m_rep = g % 3;
      end
    end else if (rep_ready_i) begin
      ack[m_grant] = 1;
      m_ptr   = (m_grant + 1) % NK;
      m_valid = 0;
    end
    // counters
    for (int i = 0; i < NK; i++) begin
      if (clear_i) begin
        m_cnt[i] = 0; m_brk[i] = 0;
      end else if (enable_i && !m_brk[i]) begin
        if (err_i[i]) m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
        else          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        if (m_cnt[i] >= TH) begin
          m_brk[i] = 1; setp[i] = 1;
        end
      end
    end
    for (int i = 0; i < NK; i++) begin
      m_pend[i] = clear_i ? 1'b0 : ((m_pend[i] && !ack[i]) || setp[i]);
    end
  endtask

  task automatic check_all();
    logic [NK-1:0] eb;
    logic [NM-1:0] ef;
    bit            ep;
    int            c;
    ep = 0;
    for (int i = 0; i < NK; i++) begin
      eb[i] = m_brk[i];
      ep    = ep | m_pend[i];
    end
    for (int m = 0; m < NM; m++) begin
      c = m_brk[3*m] + m_brk[3*m+1] + m_brk[3*m+2];
      ef[m] = (c >= 2);
    end
    chk("set_broken", 32'(set_broken_o), 32'(eb));
    chk("fatal",      32'(fatal_o),      32'(ef));
    chk("pending",    32'(pending_o),    32'(ep));
    chk("rep_valid",  32'(rep_valid_o),  32'(m_valid));
    chk("rep_mod",    32'(rep_mod_o),    32'(m_mod));
    chk("rep_replica",32'(rep_replica_o),32'(m_rep));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit pat [8];
    n_assert = 0;
    n_fail   = 0;
    pat = '{1, 1, 0, 1, 0, 0, 1, 1};

    // ---- reset with all errors asserted
    rst_n = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
    err_i = '1; err_s = '0; rep_ready_i = 1'b0;
    cyc(); cyc();
    chk("reset_all_zero", {set_broken_o, fatal_o, rep_valid_o, rep_mod_o, rep_replica_o, pending_o}, 32'h0);
    rst_n = 1'b1; err_i = '0;

    // ---- threshold: PRBU replica 1 (bit 4)
    err_i[4] = 1'b1;
    cyc(); cyc();
    chk("thr_not_yet", 32'(set_broken_o[4]), 32'h0);
    cyc();
    err_i = '0;
    chk("thr_broken", 32'(set_broken_o[4]), 32'h1);
    chk("thr_pending", 32'(pending_o), 32'h1);
    chk("thr_no_report_yet", 32'(rep_valid_o), 32'h0);
    cyc();
    chk("thr_report", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0111);
    rep_ready_i = 1'b1;
    cyc();
    chk("thr_accepted", 32'(rep_valid_o), 32'h0);
    rep_ready_i = 1'b0;
    clear_i = 1'b1; cyc(); clear_i = 1'b0;

    // ---- leak on bit 0: 1,1,0,1,0,0 then 1,1 stays below threshold
    for (int i = 0; i < 8; i++) begin
      err_i[0] = pat[i];
      cyc();
    end
    chk("leak_not_broken", 32'(set_broken_o[0]), 32'h0);
    err_i[0] = 1'b1; cyc(); err_i = '0;
    chk("leak_third_breaks", 32'(set_broken_o[0]), 32'h1);
    rep_ready_i = 1'b1;
    repeat (3) cyc();
    rep_ready_i = 1'b0;
    clear_i = 1'b1; cyc(); clear_i = 1'b0;

    // ---- round robin with backpressure: bits 2, 7, 15 break together
    err_i[2] = 1'b1; err_i[7] = 1'b1; err_i[15] = 1'b1;
    repeat (3) cyc();
    err_i = '0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_hold", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0102);
    end
    rep_ready_i = 1'b1;
    cyc(); chk("rr_gap1", 32'(rep_valid_o), 32'h0);
    cyc(); chk("rr_second", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0121);
    cyc(); chk("rr_gap2", 32'(rep_valid_o), 32'h0);
    cyc(); chk("rr_third", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0150);
    cyc(); chk("rr_done", 32'(pending_o), 32'h0);
    rep_ready_i = 1'b0;
    clear_i = 1'b1; cyc(); clear_i = 1'b0;

    // ---- fatal and clear during a report
    err_i[15] = 1'b1; err_i[17] = 1'b1;
    repeat (3) cyc();
    err_i = '0;
    chk("fatal_set", 32'(fatal_o), 32'h20);
    cyc();
    chk("fatal_report", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0152);
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    chk("clr_state", {set_broken_o, fatal_o, pending_o}, 32'h0);
    chk("clr_report_kept", {rep_valid_o, 1'b0, rep_mod_o, 2'b0, rep_replica_o}, 32'h0000_0152);
    rep_ready_i = 1'b1;
    cyc(); chk("clr_report_done", 32'(rep_valid_o), 32'h0);
    cyc(); chk("clr_stay_idle", 32'(rep_valid_o), 32'h0);
    rep_ready_i = 1'b0;

    // ---- saturation on the high-threshold instance
    err_s[0] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 253) chk("sat_below", 32'(s_set_broken[0]), 32'h0);
      if (i == 254) chk("sat_reach", 32'(s_set_broken[0]), 32'h1);
      if (i == 299) chk("sat_hold",  32'(s_set_broken[0]), 32'h1);
    end
    err_s = '0;

    // ---- randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      enable_i    = ($urandom_range(0, 7) != 0);
      clear_i     = ($urandom_range(0, 63) == 0);
      rep_ready_i = $urandom_range(0, 1) == 1;
      for (int k = 0; k < NK; k++) begin
        err_i[k] = ($urandom_range(0, 29) == 0);
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
